// File: rtl/sm_trace_monitor.sv
// Execution-trace and watchdog monitor for sm_cpu: circular trace of {stamp, pc, instr} plus halt/timeout detection.
// Latency: capture lands on the enabled edge; rd_data is registered, valid one cycle after rd_idx.
// Backpressure: none; capture never stalls the CPU, reads are accepted every cycle. Optional macro SM_TRACE_NOP_FILTER_EN skips instr==0 writes.
module sm_trace_monitor #(
    parameter int DEPTH       = 16,
    parameter int PC_W        = 16,
    parameter int CYC_W       = 16,
    parameter int TIMEOUT     = 120,
    parameter int STALL_LIMIT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_clr,
    input  logic [31:0]                   i_pc,
    input  logic [31:0]                   i_instr,
    input  logic [$clog2(DEPTH)-1:0]      i_rd_idx,
    output logic [CYC_W+PC_W+31:0]        o_rd_data,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [CYC_W-1:0]              o_cycle,
    output logic [1:0]                    o_state,
    output logic                          o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = CYC_W + PC_W + 32;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic [AW:0]      LP_FULL    = (AW+1)'(DEPTH);
    localparam logic [SW-1:0]    LP_STALL   = SW'(STALL_LIMIT);
    localparam bit               LP_WD_EN   = (TIMEOUT != 0);
    localparam logic [CYC_W-1:0] LP_TO_LAST = CYC_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_HALT    = 2'b10,
        S_TIMEOUT = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW:0]       r_count;
    logic [CYC_W-1:0]  r_cycle;
    logic [SW-1:0]     r_stall;
    logic [31:0]       r_prev_pc;
    logic [DW-1:0]     r_rd_data;

    logic              w_adv;
    logic              w_skip;
    logic              w_wr;
    logic [SW-1:0]     w_stall_nxt;
    logic              w_halt;
    logic              w_tout;
    logic [AW-1:0]     w_rd_addr;
    logic              w_rd_hit;

`ifdef SM_TRACE_NOP_FILTER_EN
    // NOP cycles still advance time and stall/watchdog tracking, they just leave no entry
    assign w_skip = (i_instr == 32'h0);
`else
    assign w_skip = 1'b0;
`endif

    // A cycle "advances" the monitor whenever capture is enabled and we are not in a terminal state
    assign w_adv       = i_en && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_wr        = w_adv && !w_skip;
    // The first captured cycle has no predecessor, so it always counts as a fresh pc
    assign w_stall_nxt = ((r_state == S_RUN) && (i_pc == r_prev_pc)) ? (r_stall + SW'(1)) : SW'(1);
    assign w_halt      = w_adv && (w_stall_nxt >= LP_STALL);
    assign w_tout      = w_adv && LP_WD_EN && (r_cycle == LP_TO_LAST);
    // Oldest valid entry sits count slots behind the write pointer; when full that is wp itself
    assign w_rd_addr   = r_wp - r_count[AW-1:0] + i_rd_idx;
    assign w_rd_hit    = ({1'b0, i_rd_idx} < r_count);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: clr beats everything, HALT beats TIMEOUT, terminal states hold
    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_adv) begin
                        if (w_halt)      w_state_nxt = S_HALT;
                        else if (w_tout) w_state_nxt = S_TIMEOUT;
                        else             w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        o_state = r_state;
        o_done  = (r_state == S_HALT) || (r_state == S_TIMEOUT);
    end

    // Capture bookkeeping: write pointer, fill level, run-cycle counter, stall tracking, read register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp      <= '0;
            r_count   <= '0;
            r_cycle   <= '0;
            r_stall   <= '0;
            r_prev_pc <= '0;
            r_rd_data <= '0;
        end else if (i_clr) begin
            r_wp      <= '0;
            r_count   <= '0;
            r_cycle   <= '0;
            r_stall   <= '0;
            r_prev_pc <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_hit ? r_mem[w_rd_addr] : '0;
            if (w_adv) begin
                r_stall   <= w_stall_nxt;
                r_prev_pc <= i_pc;
                if (r_cycle != '1) r_cycle <= r_cycle + CYC_W'(1);
            end
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
                if (r_count != LP_FULL) r_count <= r_count + (AW+1)'(1);
            end
        end
    end

    // Trace storage; contents are meaningless outside the valid window, so no reset
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_clr) r_mem[r_wp] <= {r_cycle, i_pc[PC_W-1:0], i_instr};
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;
    assign o_cycle   = r_cycle;

endmodule
